dct_block_engine: RTL
=====================

# dct_block_engine

Parametrised Avalon-MM slave computing orthonormal 8-point DCT-II or inverse DCT (DCT-III) on up to ROWS buffered 8-sample rows per job. Software fills an input buffer, writes START, polls STATUS or waits for the interrupt, then reads results from an output buffer. A single time-multiplexed MAC evaluates one output sample every 9 cycles, replacing a fully combinational butterfly. The block sits on the same Avalon bus as the existing DCT slave in the video-compression pipeline.

## Interface
- DATA_W, 16, signed sample width for inputs and outputs (8..16)
- ROWS, 8, input/output buffer depth in 8-sample rows (1..8)
- csi_clk  in  1  clock
- rsi_reset_n  in  1  asynchronous active-low reset
- avs_s0_address  in  8  word address
- avs_s0_write  in  1  write strobe
- avs_s0_writedata  in  32  write data
- avs_s0_read  in  1  read strobe
- avs_s0_readdata  out  32  read data, fixed 1-cycle read latency, reset 0
- ins_irq0_irq  out  1  level interrupt = done & irq_en, reset 0

## Operation
- Address map:
  - 0x00-0x3F: input buffer, word r*8+n. Writes take writedata[DATA_W-1:0]. Readback is sign-extended.
  - 0x40-0x7F: output buffer, read-only, sign-extended.
  - 0x80 CTRL: bit0 START (write-1 pulse, reads 0), bit1 mode (0 = DCT, 1 = IDCT), bit2 irq_en.
  - 0x81 STATUS: bit0 busy, bit1 done (sticky, write-1-to-clear), bits[11:8] rows completed.
  - 0x82 NROWS: bits[3:0]. 0 clamps to 1; values above ROWS clamp to ROWS.
  - Rows at or beyond ROWS, and all other addresses, read 0; writes to them are ignored.
- Arithmetic:
  - Coefficient C[k][n] = round(2^14 · c(k)/2 · cos((2n+1)kπ/16)), with c(0) = 1/√2 and c(k) = 1 otherwise. Signed 16-bit Q1.14; C[0][n] = 5793, C[1][0] = 8035.
  - DCT: y[k] = Σn C[k][n]·x[n]. IDCT uses the transpose C[n][k].
  - Accumulator is DATA_W+19 bits, signed, exact.
  - Result = (acc + 2^13) >>> 14 (arithmetic shift), then saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- FSM states:
  - IDLE → MAC on accepted START.
  - MAC: 8 cycles, n = 0..7.
  - WB: 1 cycle. Writes output[row][k], clears the accumulator, then advances k, or row when k wraps 7→0.
  - WB → MAC while rows remain; WB → IDLE after the last output, setting done.
- Rules:
  - START while busy is ignored.
  - START in IDLE clears done and the rows-completed count.
  - Input-buffer and CTRL-mode writes while busy are ignored. irq_en is always writable.
  - Output-buffer reads while busy return current contents.
  - done set and W1C in the same cycle: set wins.
- Reset at any time: FSM → IDLE; CTRL, STATUS, NROWS (= 1) and readdata → reset values; in-flight job is aborted. Buffers are RAM, not reset, and undefined until written.

## Timing
- START accepted on edge T. busy reads 1 from a read issued at T+1.
- Output k of row r is written at T + 9·(8r + k) + 9.
- done and irq assert at edge T + 72·NROWS + 1. Example: NROWS = 1 gives T+73.
- Read issued at edge t returns data at edge t+1. A read concurrent with a write to the same address returns the old value.
- Throughput is 72 cycles per row. No waitrequest; the slave never stalls.

## Structure
- dct_pkg holds: coefficient table COEF[0:7][0:7] as a localparam array, COEF_FRAC = 14, register address localparams, FSM state enum.
- Sub-module dct_mac holds the signed multiply-accumulate, clear, round and saturate logic, parametrised on DATA_W.
- The top level holds the bus decode, both buffers, control/status registers and the FSM.

## Test plan
- Reset, then read 0x81, 0x82 and 0x80 → 0x0, 0x1, 0x0; ins_irq0_irq = 0.
- DC input: NROWS = 1, x[0..7] = 100, DCT. Expect output 0x40 = 283 and 0x41-0x47 = 0; done at T+73.
- Impulse: x[0] = 1000, rest 0. DCT gives y0 = 354, y1 = 490. IDCT of y = (283, 0…0) returns all 100 ±1.
- Saturation: x[0..7] = 32767 → y0 = 32767. x[0..7] = −32768 → y0 = −32768.
- Multi-row job: NROWS = 8 with distinct rows and irq_en = 1; IRQ at T+577. START and input writes during busy are ignored. W1C on done drops the IRQ; if a clear lands in the done-set cycle, done stays set.
- Reset asserted mid-job at T+30 → busy = 0, done = 0, no IRQ. A new job afterwards completes with correct results.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants, register map, bus word layouts and FSM states for the DCT engine.
package dct_pkg;

  localparam int unsigned COEF_W    = 16;
  localparam int unsigned COEF_FRAC = 14;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned BUS_W     = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 8'h80;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 8'h81;
  localparam logic [ADDR_W-1:0] ADDR_NROWS  = 8'h82;

  // Orthonormal DCT-II basis, Q1.14, indexed [k][n]
  localparam logic signed [COEF_W-1:0] COEF [0:7][0:7] = '{
    '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
    '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035},
    '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568},
    '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811},
    '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
    '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551},
    '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135},
    '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598}
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [28:0] rsvd;
    logic        irq_en;
    logic        mode;
    logic        start;
  } ctrl_word_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  rows_done;
    logic [5:0]  rsvd_lo;
    logic        done;
    logic        busy;
  } status_word_t;

  // Row count written by software, forced into 1..max_rows
  function automatic logic [3:0] clamp_rows(input logic [3:0] v, input logic [3:0] max_rows);
    if (v == 4'd0) return 4'd1;
    if (v > max_rows) return max_rows;
    return v;
  endfunction

endpackage

// File: rtl/dct_mac.sv
// Signed multiply-accumulate with clear, Q14 round-half-up and saturation to DATA_W.
module dct_mac
  import dct_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [DATA_W-1:0] result_c
);

  localparam int unsigned PW = DATA_W + COEF_W;
  localparam int unsigned AW = DATA_W + 19;
  localparam int unsigned RW = AW + 1;
  localparam int unsigned SW = RW - COEF_FRAC;
  localparam logic signed [RW-1:0] HALF = RW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] acc_q;
  logic signed [RW-1:0] rnd_c;
  logic signed [SW-1:0] shr_c;

  assign prod_c = PW'(x) * PW'(coef);
  assign rnd_c  = RW'(acc_q) + HALF;
  assign shr_c  = SW'(rnd_c >>> COEF_FRAC);

  // Exact accumulator; clear has priority over accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + AW'(prod_c);
    end
  end

  // Clip the rounded value into the sample range
  always_comb begin
    result_c = shr_c[DATA_W-1:0];
    if (shr_c > MAXV) begin
      result_c = MAXV[DATA_W-1:0];
    end else if (shr_c < MINV) begin
      result_c = MINV[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/dct_block_engine.sv
// Avalon-MM 8-point DCT/IDCT engine: buffers, control/status registers and sequencing FSM.
module dct_block_engine
  import dct_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROWS   = 8
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [ADDR_W-1:0] avs_s0_address,
  input  logic              avs_s0_write,
  input  logic [BUS_W-1:0]  avs_s0_writedata,
  input  logic              avs_s0_read,
  output logic [BUS_W-1:0]  avs_s0_readdata,
  output logic              ins_irq0_irq
);

  localparam int unsigned DEPTH    = ROWS * 8;
  localparam logic [3:0]  ROWS_MAX = 4'(ROWS);

  state_t     state_q, state_d;
  logic [2:0] n_q, n_d, k_q, k_d, row_q, row_d;
  logic       mac_en_c, mac_clr_c, wb_c, last_c;
  logic       fin_q;
  logic       busy_c, start_c, ctrl_wr_c, status_wr_c, nrows_wr_c, in_wr_c, buf_row_ok_c;
  logic       mode_q, irq_en_q, irq_en_d, done_q, done_d;
  logic [3:0] nrows_q, job_rows_q, rows_done_q;
  logic [5:0] bus_idx_c;
  logic [BUS_W-1:0] rdata_c;
  ctrl_word_t   rd_ctrl_c;
  status_word_t rd_status_c;
  logic         unused_c;

  logic signed [DATA_W-1:0] in_buf  [DEPTH];
  logic signed [DATA_W-1:0] out_buf [DEPTH];
  logic signed [DATA_W-1:0] mac_x_c, mac_res_c;
  logic signed [COEF_W-1:0] mac_coef_c;

  assign unused_c = ^avs_s0_writedata[BUS_W-1:DATA_W];

  // Bus decode
  assign busy_c       = (state_q != ST_IDLE) || fin_q;
  assign bus_idx_c    = avs_s0_address[5:0];
  assign buf_row_ok_c = ({1'b0, avs_s0_address[5:3]} < ROWS_MAX);
  assign ctrl_wr_c    = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign status_wr_c  = avs_s0_write && (avs_s0_address == ADDR_STATUS);
  assign nrows_wr_c   = avs_s0_write && (avs_s0_address == ADDR_NROWS);
  assign in_wr_c      = avs_s0_write && (avs_s0_address[7:6] == 2'b00) && buf_row_ok_c && !busy_c;
  assign start_c      = ctrl_wr_c && avs_s0_writedata[0] && !busy_c;

  // Operand select: IDCT walks the transposed basis
  assign mac_x_c    = in_buf[{row_q, n_q}];
  assign mac_coef_c = mode_q ? COEF[n_q][k_q] : COEF[k_q][n_q];

  dct_mac #(.DATA_W(DATA_W)) u_mac (
    .clk      (csi_clk),
    .rst_n    (rsi_reset_n),
    .clr      (mac_clr_c),
    .en       (mac_en_c),
    .x        (mac_x_c),
    .coef     (mac_coef_c),
    .result_c (mac_res_c)
  );

  // FSM state and sample/output/row counters
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      row_q   <= row_d;
    end
  end

  // Next state: 8 MAC cycles then one write-back per output sample
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    row_d     = row_q;
    mac_en_c  = 1'b0;
    mac_clr_c = 1'b0;
    wb_c      = 1'b0;
    last_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d   = ST_MAC;
          n_d       = '0;
          k_d       = '0;
          row_d     = '0;
          mac_clr_c = 1'b1;
        end
      end
      ST_MAC: begin
        mac_en_c = 1'b1;
        n_d      = n_q + 3'd1;
        if (n_q == 3'd7) state_d = ST_WB;
      end
      ST_WB: begin
        wb_c      = 1'b1;
        mac_clr_c = 1'b1;
        k_d       = k_q + 3'd1;
        state_d   = ST_MAC;
        if (k_q == 3'd7) begin
          row_d = row_q + 3'd1;
          if (4'(row_q) + 4'd1 == job_rows_q) begin
            last_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of done and irq_en; a done set beats a same-cycle clear
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr_c) irq_en_d = avs_s0_writedata[2];
    done_d = done_q;
    if (start_c) begin
      done_d = 1'b0;
    end else if (fin_q) begin
      done_d = 1'b1;
    end else if (status_wr_c && avs_s0_writedata[1]) begin
      done_d = 1'b0;
    end
  end

  // Control/status registers and interrupt
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      mode_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      fin_q        <= 1'b0;
      nrows_q      <= 4'd1;
      job_rows_q   <= 4'd1;
      rows_done_q  <= '0;
      ins_irq0_irq <= 1'b0;
    end else begin
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      fin_q        <= last_c;
      ins_irq0_irq <= done_d & irq_en_d;
      if (ctrl_wr_c && !busy_c) mode_q <= avs_s0_writedata[1];
      if (nrows_wr_c) nrows_q <= clamp_rows(avs_s0_writedata[3:0], ROWS_MAX);
      if (start_c) begin
        job_rows_q  <= nrows_q;
        rows_done_q <= '0;
      end else if (wb_c && (k_q == 3'd7)) begin
        rows_done_q <= rows_done_q + 4'd1;
      end
    end
  end

  // Sample buffers (plain RAM, no reset)
  always_ff @(posedge csi_clk) begin
    if (in_wr_c) in_buf[bus_idx_c] <= avs_s0_writedata[DATA_W-1:0];
    if (wb_c) out_buf[{row_q, k_q}] <= mac_res_c;
  end

  // Read mux
  always_comb begin
    rdata_c               = '0;
    rd_ctrl_c             = '0;
    rd_ctrl_c.mode        = mode_q;
    rd_ctrl_c.irq_en      = irq_en_q;
    rd_status_c           = '0;
    rd_status_c.busy      = busy_c;
    rd_status_c.done      = done_q;
    rd_status_c.rows_done = rows_done_q;
    if (!avs_s0_address[7]) begin
      if (buf_row_ok_c) begin
        rdata_c = avs_s0_address[6] ? BUS_W'(out_buf[bus_idx_c]) : BUS_W'(in_buf[bus_idx_c]);
      end
    end else begin
      case (avs_s0_address)
        ADDR_CTRL:   rdata_c = rd_ctrl_c;
        ADDR_STATUS: rdata_c = rd_status_c;
        ADDR_NROWS:  rdata_c = BUS_W'(nrows_q);
        default:     rdata_c = '0;
      endcase
    end
  end

  // One-cycle registered read data
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      avs_s0_readdata <= '0;
    end else if (avs_s0_read) begin
      avs_s0_readdata <= rdata_c;
    end
  end

endmodule
